// File: rtl/pe_block_mac8x4_pkg.sv
// Shared widths, step counter sizing and FSM state type for the 8-row MAC tile.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pe_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int ROWS   = 8;
    localparam int DEPTH  = 4;
    localparam int STEP_W = $clog2(DEPTH);

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [STEP_W-1:0]        step_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/pe_block_mac8x4_if.sv
// Bus bundle for the MAC tile: broadcast activation, per-row weight/bias in, per-row results and valid out.
// Latency: n/a (wiring only).
// Backpressure: none; results are a one-cycle valid pulse with no ready.
// Ports: ifmap, weight0..7, bias0..7, i_en (master->slave); ofmap0..7, valid (slave->master).
interface pe_block_mac8x4_if;
    import pe_pkg::*;

    data_t ifmap;
    data_t weight0, weight1, weight2, weight3, weight4, weight5, weight6, weight7;
    acc_t  bias0, bias1, bias2, bias3, bias4, bias5, bias6, bias7;
    logic  i_en;
    acc_t  ofmap0, ofmap1, ofmap2, ofmap3, ofmap4, ofmap5, ofmap6, ofmap7;
    logic  valid;

    modport master (
        output ifmap,
        output weight0, weight1, weight2, weight3, weight4, weight5, weight6, weight7,
        output bias0, bias1, bias2, bias3, bias4, bias5, bias6, bias7,
        output i_en,
        input  ofmap0, ofmap1, ofmap2, ofmap3, ofmap4, ofmap5, ofmap6, ofmap7,
        input  valid
    );

    modport slave (
        input  ifmap,
        input  weight0, weight1, weight2, weight3, weight4, weight5, weight6, weight7,
        input  bias0, bias1, bias2, bias3, bias4, bias5, bias6, bias7,
        input  i_en,
        output ofmap0, ofmap1, ofmap2, ofmap3, ofmap4, ofmap5, ofmap6, ofmap7,
        output valid
    );
endinterface

// File: rtl/pe_block_mac8x4_row_mac.sv
// One MAC row: signed 8x8 product, sign-extended and added (mod 2^32) to bias on load or to the running acc.
// Latency: result registered one cycle after each load/acc_en step.
// Backpressure: none; holds its value whenever neither load nor acc_en is set.
// Ports: clk, rst (async active-low), load_i, acc_en_i, ifmap_i, weight_i, bias_i -> acc_o.
module pe_row_mac
    import pe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  acc_en_i,
    input  data_t ifmap_i,
    input  data_t weight_i,
    input  acc_t  bias_i,
    output acc_t  acc_o
);
    logic signed [2*DATA_W-1:0] prod;
    acc_t                       base;
    acc_t                       acc_d;
    acc_t                       acc_q;

    assign prod  = ifmap_i * weight_i;
    // The first step of a computation replaces the old result with the bias.
    assign base  = load_i ? bias_i : acc_q;
    assign acc_d = base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (load_i || acc_en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/pe_block_mac8x4.sv
// 8-row MAC tile: DEPTH-step dot product per row plus bias, valid pulsed for one cycle on completion.
// Latency: result and valid appear after the DEPTH-th accepted step (start edge + DEPTH-1 edges).
// Backpressure: none; i_en is ignored while busy, back-to-back start allowed on the valid cycle.
// Ports: clk, rst (async active-low), bus (slave modport: ifmap, weight0..7, bias0..7, i_en, ofmap0..7, valid).
module pe_block_mac8x4
    import pe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pe_block_mac8x4_if.slave   bus
);
    state_e state_q, state_d;
    step_t  step_q, step_d;
    logic   valid_q, valid_d;
    logic   load;
    logic   acc_en;

    data_t  w_arr   [ROWS];
    acc_t   b_arr   [ROWS];
    acc_t   acc_arr [ROWS];

    assign w_arr[0] = bus.weight0;
    assign w_arr[1] = bus.weight1;
    assign w_arr[2] = bus.weight2;
    assign w_arr[3] = bus.weight3;
    assign w_arr[4] = bus.weight4;
    assign w_arr[5] = bus.weight5;
    assign w_arr[6] = bus.weight6;
    assign w_arr[7] = bus.weight7;

    assign b_arr[0] = bus.bias0;
    assign b_arr[1] = bus.bias1;
    assign b_arr[2] = bus.bias2;
    assign b_arr[3] = bus.bias3;
    assign b_arr[4] = bus.bias4;
    assign b_arr[5] = bus.bias5;
    assign b_arr[6] = bus.bias6;
    assign b_arr[7] = bus.bias7;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        valid_d = 1'b0;
        load    = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_en) begin
                    load    = 1'b1;
                    step_d  = step_t'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // i_en is deliberately not looked at here: a run always completes.
                acc_en = 1'b1;
                if (step_q == step_t'(DEPTH-1)) begin
                    valid_d = 1'b1;
                    step_d  = '0;
                    state_d = IDLE;
                end else begin
                    step_d  = step_q + step_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        pe_row_mac u_row (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load),
            .acc_en_i (acc_en),
            .ifmap_i  (bus.ifmap),
            .weight_i (w_arr[r]),
            .bias_i   (b_arr[r]),
            .acc_o    (acc_arr[r])
        );
    end

    assign bus.ofmap0 = acc_arr[0];
    assign bus.ofmap1 = acc_arr[1];
    assign bus.ofmap2 = acc_arr[2];
    assign bus.ofmap3 = acc_arr[3];
    assign bus.ofmap4 = acc_arr[4];
    assign bus.ofmap5 = acc_arr[5];
    assign bus.ofmap6 = acc_arr[6];
    assign bus.ofmap7 = acc_arr[7];
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_pe_block_mac8x4.sv
// Directed bench for the MAC tile: transaction-level model checked every cycle plus literal result pins.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_pe_block_mac8x4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_block_mac8x4_if bus ();

    pe_block_mac8x4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  tb_a;
    logic [7:0]  tb_w [8];
    logic [31:0] tb_b [8];
    logic        tb_en;

    assign bus.ifmap   = tb_a;
    assign bus.i_en    = tb_en;
    assign bus.weight0 = tb_w[0];
    assign bus.weight1 = tb_w[1];
    assign bus.weight2 = tb_w[2];
    assign bus.weight3 = tb_w[3];
    assign bus.weight4 = tb_w[4];
    assign bus.weight5 = tb_w[5];
    assign bus.weight6 = tb_w[6];
    assign bus.weight7 = tb_w[7];
    assign bus.bias0   = tb_b[0];
    assign bus.bias1   = tb_b[1];
    assign bus.bias2   = tb_b[2];
    assign bus.bias3   = tb_b[3];
    assign bus.bias4   = tb_b[4];
    assign bus.bias5   = tb_b[5];
    assign bus.bias6   = tb_b[6];
    assign bus.bias7   = tb_b[7];

    logic [31:0] dut_of [8];
    assign dut_of[0] = bus.ofmap0;
    assign dut_of[1] = bus.ofmap1;
    assign dut_of[2] = bus.ofmap2;
    assign dut_of[3] = bus.ofmap3;
    assign dut_of[4] = bus.ofmap4;
    assign dut_of[5] = bus.ofmap5;
    assign dut_of[6] = bus.ofmap6;
    assign dut_of[7] = bus.ofmap7;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: remember the inputs of the current computation and recompute bias + sum of the steps seen so far.
    logic [31:0] m_bias [8];
    logic [7:0]  m_a    [4];
    logic [7:0]  m_w    [8][4];
    int          m_k    = 0;
    bit          m_busy = 1'b0;
    logic [31:0] exp_of [8];
    bit          exp_vld = 1'b0;

    task automatic model_reset();
        for (int r = 0; r < 8; r++) exp_of[r] = 32'h0;
        m_busy  = 1'b0;
        m_k     = 0;
        exp_vld = 1'b0;
    endtask

    task automatic model_recompute();
        for (int r = 0; r < 8; r++) begin
            int s;
            s = int'(m_bias[r]);
            for (int j = 0; j < m_k; j++) begin
                int p;
                p = int'($signed(m_a[j])) * int'($signed(m_w[r][j]));
                s = s + p;
            end
            exp_of[r] = s;
        end
    endtask

    task automatic model_update();
        exp_vld = 1'b0;
        if (!m_busy) begin
            if (tb_en) begin
                for (int r = 0; r < 8; r++) begin
                    m_bias[r]  = tb_b[r];
                    m_w[r][0]  = tb_w[r];
                end
                m_a[0] = tb_a;
                m_k    = 1;
                m_busy = 1'b1;
                model_recompute();
            end
        end else begin
            m_a[m_k] = tb_a;
            for (int r = 0; r < 8; r++) m_w[r][m_k] = tb_w[r];
            m_k = m_k + 1;
            model_recompute();
            if (m_k == 4) begin
                m_busy  = 1'b0;
                exp_vld = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int r = 0; r < 8; r++) chk($sformatf("ofmap%0d", r), dut_of[r], exp_of[r]);
        chk("valid", {31'b0, bus.valid}, {31'b0, exp_vld});
    endtask

    // One clock: model sees the edge, outputs are compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        else     model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_all(input logic [7:0] w, input logic [31:0] b0, input logic [31:0] bstep);
        for (int r = 0; r < 8; r++) begin
            tb_w[r] = w;
            tb_b[r] = b0 + bstep * r;
        end
    endtask

    // Full computation with en only on the first step; leaves the bench on the negedge after T3.
    task automatic comp(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        tb_en = 1'b1; tb_a = a0; tick();
        tb_en = 1'b0; tb_a = a1; tick();
        tb_a = a2; tick();
        tb_a = a3; tick();
    endtask

    initial begin
        tb_en = 1'b0;
        tb_a  = 8'h0;
        set_all(8'h0, 32'h0, 32'h0);
        model_reset();
        #12;
        for (int r = 0; r < 8; r++) chk($sformatf("rst_ofmap%0d", r), dut_of[r], 32'h0);
        chk("rst_valid", {31'b0, bus.valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Basic: bias_r = r, ifmap 1..4, weights 1 -> r+10.
        set_all(8'd1, 32'd0, 32'd1);
        comp(8'd1, 8'd2, 8'd3, 8'd4);
        for (int r = 0; r < 8; r++) chk($sformatf("basic_ofmap%0d", r), dut_of[r], 32'(r + 10));
        chk("basic_valid", {31'b0, bus.valid}, 32'd1);
        tick();
        chk("basic_valid_drop", {31'b0, bus.valid}, 32'd0);

        // Signed: -1 * 2 over four steps -> -8.
        set_all(8'd2, 32'd0, 32'd0);
        comp(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("signed_neg", dut_of[0], 32'hFFFF_FFF8);
        tick();

        // Signed extreme: (-128)*(-128)*4 = 65536.
        set_all(8'h80, 32'd0, 32'd0);
        comp(8'h80, 8'h80, 8'h80, 8'h80);
        chk("signed_min", dut_of[0], 32'h0001_0000);
        tick();

        // Wrap: 0x7FFFFFFF + 4 wraps to 0x80000003.
        set_all(8'd1, 32'h7FFF_FFFF, 32'd0);
        comp(8'd1, 8'd1, 8'd1, 8'd1);
        chk("wrap", dut_of[0], 32'h8000_0003);
        tick();

        // Busy: en again at T1 ignored, then back-to-back start on the valid cycle.
        set_all(8'd1, 32'd0, 32'd3);
        tb_en = 1'b1; tb_a = 8'd1; tick();
        tb_en = 1'b1; tb_a = 8'd2; tick();
        tb_en = 1'b0; tb_a = 8'd3; tick();
        tb_a = 8'd4; tick();
        for (int r = 0; r < 8; r++) chk($sformatf("busy_ofmap%0d", r), dut_of[r], 32'(3 * r + 10));
        chk("busy_valid", {31'b0, bus.valid}, 32'd1);
        set_all(8'd2, 32'd1000, 32'd0);
        comp(8'd5, 8'd6, 8'd7, 8'd8);
        chk("b2b_ofmap0", dut_of[0], 32'd1052);
        chk("b2b_valid", {31'b0, bus.valid}, 32'd1);

        // Hold: no start, inputs toggling -> result frozen, no valid.
        for (int i = 0; i < 10; i++) begin
            tb_a = 8'($urandom);
            for (int r = 0; r < 8; r++) tb_w[r] = 8'($urandom);
            tick();
        end
        chk("hold_ofmap0", dut_of[0], 32'd1052);
        chk("hold_valid", {31'b0, bus.valid}, 32'd0);

        // Reset mid-run: partial sums visible, then async reset clears everything.
        set_all(8'd1, 32'd100, 32'd1);
        tb_en = 1'b1; tb_a = 8'd1; tick();
        tb_en = 1'b0; tb_a = 8'd2; tick();
        chk("partial_ofmap0", dut_of[0], 32'd103);
        #2 rst = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) chk($sformatf("midrst_ofmap%0d", r), dut_of[r], 32'h0);
        chk("midrst_valid", {31'b0, bus.valid}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tb_a = 8'd3;
            tick();
        end
        chk("post_rst_valid", {31'b0, bus.valid}, 32'h0);
        chk("post_rst_ofmap0", dut_of[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
